// File: rtl/ransac_pkg.sv
// Shared definitions for the RANSAC point loader: FSM states, CSR map and
// point-word field layout.
package ransac_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_WRITE = 2'd2,
        ST_DONE  = 2'd3
    } loader_state_e;

    localparam logic [1:0] CSR_CTRL   = 2'd0;
    localparam logic [1:0] CSR_BASE   = 2'd1;
    localparam logic [1:0] CSR_COUNT  = 2'd2;
    localparam logic [1:0] CSR_STATUS = 2'd3;

    localparam int CTRL_START    = 0;
    localparam int CTRL_ABORT    = 1;
    localparam int CTRL_CLR_DONE = 2;

    localparam int STAT_BUSY      = 0;
    localparam int STAT_DONE      = 1;
    localparam int STAT_ABORTED   = 2;
    localparam int STAT_WORDS_LSB = 16;

    localparam int PT_X_LSB = 0;
    localparam int PT_Y_LSB = 16;
    localparam int PT_FLD_W = 16;

    function automatic logic signed [PT_FLD_W-1:0] point_x(input logic [31:0] w);
        return w[PT_X_LSB +: PT_FLD_W];
    endfunction

    function automatic logic signed [PT_FLD_W-1:0] point_y(input logic [31:0] w);
        return w[PT_Y_LSB +: PT_FLD_W];
    endfunction

    function automatic logic [31:0] make_point(input logic signed [PT_FLD_W-1:0] x,
                                               input logic signed [PT_FLD_W-1:0] y);
        return {y, x};
    endfunction

endpackage

// File: rtl/ransac_point_loader.sv
// Streams Avalon-ST point words into the Nios data RAM through an Avalon-MM
// write master; CSR-controlled. Define LOADER_IRQ_EN to add the done interrupt.
module ransac_point_loader
    import ransac_pkg::*;
#(
    parameter int ADDR_W = 14,
    parameter int CNT_W  = 13
) (
    input  logic              clk,
    input  logic              reset_n,

    input  logic [1:0]        csr_address,
    input  logic              csr_write,
    input  logic              csr_read,
    input  logic [31:0]       csr_writedata,
    output logic [31:0]       csr_readdata,

    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       in_data,

    output logic [ADDR_W-1:0] m_address,
    output logic              m_write,
    output logic [31:0]       m_writedata,
    output logic [3:0]        m_byteenable,
`ifdef LOADER_IRQ_EN
    output logic              irq,
`endif
    input  logic              m_waitrequest
);

    localparam int unsigned MAX_WORDS = 2 ** (ADDR_W - 2);

    loader_state_e      state_q, state_d;
    logic [ADDR_W-1:0]  base_q;
    logic [CNT_W-1:0]   count_q;
    logic [CNT_W-1:0]   index_q, index_d, index_inc;
    logic [31:0]        data_q, data_d;
    logic               aborted_q, aborted_d;
    logic               abort_pend_q, abort_pend_d;
    logic [31:0]        readdata_q, rd_mux;

    logic ctrl_wr, start_req, abort_req, clr_req, busy;

    assign ctrl_wr   = csr_write && (csr_address == CSR_CTRL);
    // ABORT takes priority over a START carried in the same CTRL write.
    assign abort_req = ctrl_wr && csr_writedata[CTRL_ABORT];
    assign start_req = ctrl_wr && csr_writedata[CTRL_START] && !csr_writedata[CTRL_ABORT];
    assign clr_req   = ctrl_wr && csr_writedata[CTRL_CLR_DONE];

    assign busy      = (state_q == ST_RUN) || (state_q == ST_WRITE);
    assign index_inc = index_q + CNT_W'(1);

    // NOTE: every signal driven here gets a default first, so no path can leave
    // one unassigned and infer a latch.
    always_comb begin
        state_d      = state_q;
        index_d      = index_q;
        data_d       = data_q;
        aborted_d    = aborted_q;
        abort_pend_d = abort_pend_q;

        unique case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start_req) begin
                    index_d   = '0;
                    aborted_d = 1'b0;
                    state_d   = (count_q == '0) ? ST_DONE : ST_RUN;
                end else if (clr_req) begin
                    aborted_d = 1'b0;
                    state_d   = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (abort_req) begin
                    aborted_d = 1'b1;
                    state_d   = ST_IDLE;
                end else if (in_valid) begin
                    data_d  = in_data;
                    state_d = ST_WRITE;
                end
            end
            ST_WRITE: begin
                if (abort_req) begin
                    abort_pend_d = 1'b1;
                end
                // The in-flight write always completes; an abort only acts after it.
                if (!m_waitrequest) begin
                    index_d = index_inc;
                    if (abort_pend_q || abort_req) begin
                        abort_pend_d = 1'b0;
                        aborted_d    = 1'b1;
                        state_d      = ST_IDLE;
                    end else if (index_inc == count_q) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_RUN;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        rd_mux = '0;
        unique case (csr_address)
            CSR_BASE:   rd_mux[ADDR_W-1:0] = base_q;
            CSR_COUNT:  rd_mux[CNT_W-1:0]  = count_q;
            CSR_STATUS: begin
                rd_mux[STAT_BUSY]                = busy;
                rd_mux[STAT_DONE]                = (state_q == ST_DONE);
                rd_mux[STAT_ABORTED]             = aborted_q;
                rd_mux[STAT_WORDS_LSB +: CNT_W]  = index_q;
            end
            default:    rd_mux = '0;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so every flop
    // samples the pre-edge value of every other flop.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            index_q      <= '0;
            data_q       <= '0;
            aborted_q    <= 1'b0;
            abort_pend_q <= 1'b0;
            base_q       <= '0;
            count_q      <= '0;
            readdata_q   <= '0;
        end else begin
            state_q      <= state_d;
            index_q      <= index_d;
            data_q       <= data_d;
            aborted_q    <= aborted_d;
            abort_pend_q <= abort_pend_d;
            if (csr_write && !busy) begin
                if (csr_address == CSR_BASE) begin
                    base_q <= {csr_writedata[ADDR_W-1:2], 2'b00};
                end
                if (csr_address == CSR_COUNT) begin
                    count_q <= (csr_writedata > MAX_WORDS) ? CNT_W'(MAX_WORDS)
                                                           : csr_writedata[CNT_W-1:0];
                end
            end
            readdata_q <= csr_read ? rd_mux : '0;
        end
    end

    assign csr_readdata = readdata_q;
    assign in_ready     = (state_q == ST_RUN);
    assign m_write      = (state_q == ST_WRITE);
    // Sum truncates to ADDR_W bits, so running past the top of RAM wraps to 0.
    assign m_address    = base_q + {index_q[ADDR_W-3:0], 2'b00};
    assign m_writedata  = data_q;
    assign m_byteenable = 4'b1111;

`ifdef LOADER_IRQ_EN
    assign irq = (state_q == ST_DONE) || aborted_q;
`endif

endmodule

// File: tb/tb_ransac_point_loader.sv
// Scoreboard bench for ransac_point_loader: directed scenarios plus randomized
// runs, with a monitor checking every accepted RAM write against expectations.
module tb_ransac_point_loader;
    import ransac_pkg::*;

    localparam int ADDR_W = 14;
    localparam int CNT_W  = 13;
    localparam int ADDR_SPACE = 2 ** ADDR_W;

    logic              clk = 1'b0;
    logic              reset_n = 1'b0;
    logic [1:0]        csr_address = '0;
    logic              csr_write = 1'b0;
    logic              csr_read = 1'b0;
    logic [31:0]       csr_writedata = '0;
    logic [31:0]       csr_readdata;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [31:0]       in_data = '0;
    logic [ADDR_W-1:0] m_address;
    logic              m_write;
    logic [31:0]       m_writedata;
    logic [3:0]        m_byteenable;
    logic              m_waitrequest = 1'b0;
`ifdef LOADER_IRQ_EN
    logic              irq;
`endif

    ransac_point_loader #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .csr_address   (csr_address),
        .csr_write     (csr_write),
        .csr_read      (csr_read),
        .csr_writedata (csr_writedata),
        .csr_readdata  (csr_readdata),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_data       (in_data),
        .m_address     (m_address),
        .m_write       (m_write),
        .m_writedata   (m_writedata),
        .m_byteenable  (m_byteenable),
`ifdef LOADER_IRQ_EN
        .irq           (irq),
`endif
        .m_waitrequest (m_waitrequest)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    wr_t         exp_q[$];
    logic [31:0] src_q[$];

    int checks = 0;
    int failures = 0;
    int writes_done = 0;
    int hs_count = 0;
    int wr_seq = 0;
    int stall_target = -1;
    int stall_len = 0;
    bit rand_stalls = 1'b0;
    bit rand_gaps = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] status_word(input int words, input bit busy_f,
                                                input bit done_f, input bit aborted_f);
        return (32'(words) << 16) | (32'(aborted_f) << 2) | (32'(done_f) << 1) | 32'(busy_f);
    endfunction

    // Point source: offers queued words, optional random idle gaps.
    initial begin : source
        bit hs;
        forever begin
            @(negedge clk);
            hs = in_valid && in_ready && reset_n;
            @(posedge clk);
            #1;
            if (hs) begin
                hs_count++;
                if (src_q.size() > 0) src_q.delete(0);
            end
            if (src_q.size() > 0 && (!rand_gaps || $urandom_range(0, 3) != 0)) begin
                in_valid = 1'b1;
                in_data  = src_q[0];
            end else begin
                in_valid = 1'b0;
            end
        end
    end

    // Interconnect model: scripted stall on a chosen write, or random stalls.
    initial begin : waitreq_drv
        bit req_open;
        int stall_left;
        req_open   = 1'b0;
        stall_left = 0;
        forever begin
            @(posedge clk);
            #1;
            if (m_write) begin
                if (!req_open) begin
                    req_open = 1'b1;
                    wr_seq++;
                    if (wr_seq == stall_target) stall_left = stall_len;
                    else if (rand_stalls)       stall_left = $urandom_range(0, 3);
                    else                        stall_left = 0;
                end
                if (stall_left > 0) begin
                    m_waitrequest = 1'b1;
                    stall_left--;
                end else begin
                    m_waitrequest = 1'b0;
                    req_open      = 1'b0;
                end
            end else begin
                req_open      = 1'b0;
                m_waitrequest = rand_stalls ? 1'($urandom_range(0, 1)) : 1'b0;
            end
        end
    end

    // Monitor: pops the scoreboard on every accepted write, checks stall stability.
    logic        stall_prev = 1'b0;
    logic [31:0] a_prev, d_prev;
    initial begin : monitor
        wr_t e;
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                stall_prev = 1'b0;
            end else begin
                if (stall_prev) begin
                    check("stall_write_held",  32'(m_write), 32'd1);
                    check("stall_addr_stable", 32'(m_address), a_prev);
                    check("stall_data_stable", m_writedata, d_prev);
                    check("stall_no_in_ready", 32'(in_ready), 32'd0);
                end
                stall_prev = 1'b0;
                if (m_write && m_waitrequest) begin
                    stall_prev = 1'b1;
                    a_prev     = 32'(m_address);
                    d_prev     = m_writedata;
                end else if (m_write) begin
                    writes_done++;
                    if (exp_q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL unexpected_write: got addr 0x%04h data 0x%08h, expected no write",
                                 m_address, m_writedata);
                    end else begin
                        e = exp_q.pop_front();
                        check("write_addr", 32'(m_address), e.addr);
                        check("write_data", m_writedata, e.data);
                        check("write_byteenable", 32'(m_byteenable), 32'hF);
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic csr_wr(input logic [1:0] a, input logic [31:0] d);
        csr_address   = a;
        csr_writedata = d;
        csr_write     = 1'b1;
        @(posedge clk);
        #2;
        csr_write = 1'b0;
    endtask

    task automatic csr_rd(input logic [1:0] a, output logic [31:0] d);
        csr_address = a;
        csr_read    = 1'b1;
        @(posedge clk);
        #2;
        d        = csr_readdata;
        csr_read = 1'b0;
    endtask

    // Queue a run: expected writes at (base + 4*i) mod address space.
    task automatic load_run(input int base, input int count, input logic [31:0] words[$]);
        foreach (words[i]) begin
            wr_t e;
            e.addr = 32'((base + 4 * i) % ADDR_SPACE);
            e.data = words[i];
            exp_q.push_back(e);
            src_q.push_back(words[i]);
        end
        csr_wr(CSR_BASE, 32'(base));
        csr_wr(CSR_COUNT, 32'(count));
        csr_wr(CSR_CTRL, 32'h1 << CTRL_START);
    endtask

    task automatic wait_idle(input string name, output logic [31:0] st);
        int budget;
        budget = 2000;
        st = '1;
        while (budget > 0) begin
            csr_rd(CSR_STATUS, st);
            if (!st[STAT_BUSY]) break;
            budget--;
        end
        if (budget == 0) begin
            checks++;
            failures++;
            $display("FAIL %s_timeout: got STATUS 0x%08h, expected BUSY to clear", name, st);
        end
    endtask

    initial begin : stimulus
        logic [31:0] st, rd;
        logic [31:0] words[$];
        int hs0, w0, base, n, budget;

        // Reset values
        repeat (2) @(posedge clk);
        #2;
        check("rst_in_ready",     32'(in_ready), 32'd0);
        check("rst_m_write",      32'(m_write), 32'd0);
        check("rst_m_address",    32'(m_address), 32'd0);
        check("rst_m_writedata",  m_writedata, 32'd0);
        check("rst_csr_readdata", csr_readdata, 32'd0);
`ifdef LOADER_IRQ_EN
        check("rst_irq",          32'(irq), 32'd0);
`endif
        reset_n = 1'b1;
        @(posedge clk);
        #2;
        csr_rd(CSR_BASE, rd);    check("rst_base", rd, 32'd0);
        csr_rd(CSR_COUNT, rd);   check("rst_count", rd, 32'd0);
        csr_rd(CSR_STATUS, rd);  check("rst_status", rd, 32'd0);

        // CSR write masking and clipping
        csr_wr(CSR_BASE, 32'h0001_3237);
        csr_rd(CSR_BASE, rd);    check("base_mask", rd, 32'((32'h0001_3237 % ADDR_SPACE) & ~32'd3));
        csr_wr(CSR_COUNT, 32'd5000);
        csr_rd(CSR_COUNT, rd);   check("count_clip", rd, 32'd4096);
        csr_rd(CSR_CTRL, rd);    check("ctrl_reads_zero", rd, 32'd0);

        // Directed run, no stalls; BASE/COUNT/START while busy must be ignored
        words = '{32'h0002_0001, 32'h0004_0003, 32'h0006_0005};
        hs0 = hs_count;
        load_run(32'h100, 3, words);
        csr_wr(CSR_BASE, 32'h999);
        csr_wr(CSR_COUNT, 32'd7);
        csr_wr(CSR_CTRL, 32'h1 << CTRL_START);
        wait_idle("run1", st);
        check("run1_status", st, status_word(3, 0, 1, 0));
        check("run1_drained", 32'(exp_q.size()), 32'd0);
        check("run1_handshakes", 32'(hs_count - hs0), 32'd3);
        csr_rd(CSR_BASE, rd);    check("busy_base_ignored", rd, 32'h100);
        csr_rd(CSR_COUNT, rd);   check("busy_count_ignored", rd, 32'd3);
`ifdef LOADER_IRQ_EN
        check("run1_irq", 32'(irq), 32'd1);
`endif

        // Same run with a 5-cycle stall on the second write (START from DONE)
        stall_target = wr_seq + 2;
        stall_len    = 5;
        hs0 = hs_count;
        load_run(32'h100, 3, words);
        wait_idle("run2", st);
        check("run2_status", st, status_word(3, 0, 1, 0));
        check("run2_drained", 32'(exp_q.size()), 32'd0);
        check("run2_handshakes", 32'(hs_count - hs0), 32'd3);
        csr_wr(CSR_CTRL, 32'h1 << CTRL_CLR_DONE);
        csr_rd(CSR_STATUS, rd);  check("clr_done_status", rd, status_word(3, 0, 0, 0));

        // COUNT = 0: DONE on the next cycle, no writes
        csr_wr(CSR_COUNT, 32'd0);
        w0 = writes_done;
        csr_wr(CSR_CTRL, 32'h1 << CTRL_START);
`ifdef LOADER_IRQ_EN
        check("cnt0_irq", 32'(irq), 32'd1);
`endif
        csr_rd(CSR_STATUS, rd);  check("cnt0_status", rd, status_word(0, 0, 1, 0));
        repeat (5) @(posedge clk);
        #2;
        check("cnt0_no_writes", 32'(writes_done - w0), 32'd0);
        csr_wr(CSR_CTRL, 32'h1 << CTRL_CLR_DONE);

        // COUNT = 4, ABORT during the second write's stall
        stall_target = wr_seq + 2;
        stall_len    = 8;
        load_run(32'h200, 4, '{32'hAAAA_0001, 32'hBBBB_0002});
        budget = 500;
        while (budget > 0 && !(wr_seq == stall_target && m_waitrequest)) begin
            @(posedge clk);
            #2;
            budget--;
        end
        if (budget == 0) begin
            checks++;
            failures++;
            $display("FAIL abort_stall_timeout: got wr_seq %0d, expected stalled write %0d",
                     wr_seq, stall_target);
        end
        csr_wr(CSR_CTRL, 32'h1 << CTRL_ABORT);
        wait_idle("abort", st);
        check("abort_status", st, status_word(2, 0, 0, 1));
        check("abort_drained", 32'(exp_q.size()), 32'd0);
`ifdef LOADER_IRQ_EN
        check("abort_irq", 32'(irq), 32'd1);
`endif
        csr_wr(CSR_CTRL, 32'h1 << CTRL_CLR_DONE);
        csr_rd(CSR_STATUS, rd);  check("abort_cleared", rd, status_word(2, 0, 0, 0));
`ifdef LOADER_IRQ_EN
        check("abort_irq_cleared", 32'(irq), 32'd0);
`endif

        // START|ABORT together: ABORT wins, START dropped (stays idle)
        csr_wr(CSR_CTRL, (32'h1 << CTRL_START) | (32'h1 << CTRL_ABORT));
        csr_rd(CSR_STATUS, rd);  check("start_abort_status", rd, status_word(2, 0, 0, 0));
        check("start_abort_in_ready", 32'(in_ready), 32'd0);

        // Address wrap past the top of RAM
        load_run(32'h3FFC, 2, '{32'h1234_5678, 32'h9ABC_DEF0});
        wait_idle("wrap", st);
        check("wrap_status", st, status_word(2, 0, 1, 0));
        check("wrap_drained", 32'(exp_q.size()), 32'd0);

        // Randomized runs with random stalls and source gaps
        rand_stalls = 1'b1;
        rand_gaps   = 1'b1;
        for (int r = 0; r < 6; r++) begin
            base = int'($urandom_range(0, ADDR_SPACE - 1)) & ~3;
            n    = int'($urandom_range(1, 12));
            words.delete();
            for (int i = 0; i < n; i++) begin
                words.push_back(make_point(16'($urandom), 16'($urandom)));
            end
            load_run(base, n, words);
            wait_idle("rand", st);
            check("rand_status", st, status_word(n, 0, 1, 0));
            check("rand_drained", 32'(exp_q.size()), 32'd0);
        end
        rand_stalls = 1'b0;
        rand_gaps   = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        csr_wr(CSR_CTRL, 32'h1 << CTRL_CLR_DONE);

        // Reset asserted mid-run
        w0 = writes_done;
        load_run(32'h40, 4, '{32'h11, 32'h22, 32'h33, 32'h44});
        budget = 500;
        while (budget > 0 && !(writes_done > w0 && in_ready)) begin
            @(posedge clk);
            #2;
            budget--;
        end
        if (budget == 0) begin
            checks++;
            failures++;
            $display("FAIL midrun_wait_timeout: got %0d writes, expected a write then RUN",
                     writes_done - w0);
        end
        #1;
        reset_n = 1'b0;
        #1;
        check("midrst_in_ready",     32'(in_ready), 32'd0);
        check("midrst_m_write",      32'(m_write), 32'd0);
        check("midrst_m_address",    32'(m_address), 32'd0);
        check("midrst_m_writedata",  m_writedata, 32'd0);
        check("midrst_csr_readdata", csr_readdata, 32'd0);
`ifdef LOADER_IRQ_EN
        check("midrst_irq",          32'(irq), 32'd0);
`endif
        src_q.delete();
        exp_q.delete();
        @(posedge clk);
        #2;
        reset_n = 1'b1;
        @(posedge clk);
        #2;
        csr_rd(CSR_STATUS, rd);  check("midrst_status", rd, 32'd0);
        load_run(32'h40, 2, '{32'hCAFE_0001, 32'hCAFE_0002});
        wait_idle("postrst", st);
        check("postrst_status", st, status_word(2, 0, 1, 0));
        check("postrst_drained", 32'(exp_q.size()), 32'd0);

        repeat (3) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ransac_point_loader.md
# ransac_point_loader

Avalon-MM write master that fills the Nios data RAM (4096 x 32 single-port on-chip memory) with point samples arriving on an Avalon-ST sink, so the RANSAC software finds a contiguous point buffer ready to process. The block sits directly upstream of the data RAM's write port on the system interconnect. It is programmed and polled by the Nios through a 4-register CSR slave.

## Interface
Parameters:
- ADDR_W, 14: master byte-address width (4096 words x 4 bytes).
- CNT_W, 13: word-count width; holds 0..4096.

Ports:
- clk  in  1  system clock; the only clock.
- reset_n  in  1  reset, asynchronous, active-low.
- csr_address  in  2  CSR word offset.
- csr_write / csr_read  in  1  CSR strobes.
- csr_writedata  in  32  CSR write data.
- csr_readdata  out  32  CSR read data; read latency 1.
- in_valid  in  1  sink data valid.
- in_ready  out  1  sink ready.
- in_data  in  32  point word: [15:0] x, [31:16] y, signed.
- m_address  out  ADDR_W  byte address, always word-aligned.
- m_write  out  1  write request.
- m_writedata  out  32  data to RAM.
- m_byteenable  out  4  constant 4'b1111.
- m_waitrequest  in  1  interconnect stall.
- irq  out  1  done interrupt; present only with the macro below.

## Operation
- CSR map: 0 CTRL (W: bit0 START, bit1 ABORT, bit2 CLR_DONE; reads 0). 1 BASE (byte address; bits[1:0] forced 0). 2 COUNT (words, CNT_W bits). 3 STATUS (R: bit0 BUSY, bit1 DONE, bit2 ABORTED, bits[28:16] words written).
- FSM states: IDLE, RUN, WRITE, DONE.
- IDLE: START -> RUN; index cleared; DONE/ABORTED cleared. If COUNT = 0, START goes straight to DONE.
- RUN: in_ready = 1. When in_valid: latch in_data and go to WRITE.
- WRITE: m_write = 1 and m_address = BASE + 4*index, both held stable while m_waitrequest = 1. On the accepting cycle (m_waitrequest = 0): index increments. If index+1 = COUNT -> DONE, else -> RUN.
- DONE: DONE = 1, BUSY = 0. Any START -> RUN (new run). CLR_DONE -> IDLE.
- ABORT in RUN -> IDLE with ABORTED = 1. ABORT in WRITE is recorded; the pending write completes, then -> IDLE with ABORTED = 1. Written count reflects the completed writes.
- START while BUSY is ignored. BASE/COUNT writes while BUSY are ignored.
- Address arithmetic is modulo 2^ADDR_W: overrun past the top wraps silently. COUNT > 4096 is clipped to 4096 on write.
- Simultaneous START|ABORT in a single CTRL write: ABORT wins, and START is dropped.

## Timing
- Reset values: csr_readdata 0, in_ready 0, m_write 0, m_address 0, m_writedata 0, irq 0. BASE 0, COUNT 0, state IDLE.
- With m_waitrequest = 0, each point takes 2 cycles (RUN accept, WRITE issue), giving 1 word per 2 cycles.
- in_ready is a registered-state decode only, with no combinational path from m_waitrequest.
- DONE (and irq) assert in the cycle after the last write is accepted.
- Reset asserted mid-run: the block returns to IDLE immediately. A partial buffer in RAM is left as written.

## Configuration
- LOADER_IRQ_EN defined: irq port exists. irq = DONE | ABORTED, level-sensitive, and stays high until CLR_DONE or START.
- LOADER_IRQ_EN not defined: no irq port. Software polls STATUS.

## Structure
- Shared package ransac_pkg holds:
  - the FSM state enum;
  - CSR offset constants and CTRL/STATUS bit positions;
  - the point field slices (x = [15:0], y = [31:16]).
- This is a single module with no sub-module; the CSR decode is small enough to stay inline.

## Test plan
- BASE = 0x100, COUNT = 3, START, stream 0x00020001, 0x00040003, 0x00060005 with no stalls. Expect writes at 0x100/0x104/0x108 with matching data, then STATUS = 0x00030002.
- Same run with m_waitrequest held high for 5 cycles on the second write. Expect address and data stable throughout the stall, no extra in_ready, and a correct final count.
- COUNT = 0 then START. Expect no m_write and DONE set on the next cycle.
- COUNT = 4, ABORT during the second WRITE stall. Expect that write to complete, then IDLE with STATUS = 0x00020004.
- BASE = 0x3FFC, COUNT = 2. Expect writes at 0x3FFC, then 0x0000 (wrap).
- reset_n pulsed low mid-RUN. Expect all outputs to return to their reset values immediately, and a subsequent START to work from index 0.
